// File: rtl/usbf_wb_reg_slave.sv
// ---------------------------------------------------------------------------
// usbf_wb_reg_slave
//   Wishbone classic slave holding the USB function register file that the
//   function controller programs and polls: FA, INT_MSK, INT_SRC and, per
//   endpoint, CSR / INT / BUF0 / BUF1. USB-side event pulses are latched into
//   sticky status bits, which are combined with the mask to drive the two
//   registered interrupt lines. The buffer-memory region is decoded and
//   acknowledged here; its data path lives in a separate block.
//
// Ports
//   clk_i      system clock
//   nrst_i     asynchronous active-low reset
//   wb_addr_i  byte address; MSB=1 register file, MSB=0 buffer memory
//   wb_data_i  write data
//   wb_data_o  read data, non-zero only while wb_ack_o=1
//   wb_we_i    1=write, 0=read
//   wb_stb_i   strobe
//   wb_cyc_i   cycle valid
//   wb_ack_o   single-cycle acknowledge, one clock after the strobe is taken
//   inta_o     interrupt A (registered)
//   intb_o     interrupt B (registered)
//   usb_rst_i  one-cycle pulse: USB bus reset seen
//   attach_i   one-cycle pulse: device attached
//   ep_evt_i   per-endpoint event pulses, endpoint n on [6n+5:6n]
//   fa_o       current function address
// ---------------------------------------------------------------------------
module usbf_wb_reg_slave #(
  parameter int ADDR_W = 18,
  parameter int NUM_EP = 2
) (
  input  logic                  clk_i,
  input  logic                  nrst_i,
  input  logic [ADDR_W-1:0]     wb_addr_i,
  input  logic [31:0]           wb_data_i,
  output logic [31:0]           wb_data_o,
  input  logic                  wb_we_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_cyc_i,
  output logic                  wb_ack_o,
  output logic                  inta_o,
  output logic                  intb_o,
  input  logic                  usb_rst_i,
  input  logic                  attach_i,
  input  logic [6*NUM_EP-1:0]   ep_evt_i,
  output logic [6:0]            fa_o
);

  typedef enum logic {S_IDLE, S_ACK} state_t;

  localparam logic [7:0] OFF_FA      = 8'h04;
  localparam logic [7:0] OFF_INT_MSK = 8'h08;
  localparam logic [7:0] OFF_INT_SRC = 8'h0C;

  localparam logic [1:0] EP_CSR  = 2'd0;
  localparam logic [1:0] EP_INT  = 2'd1;
  localparam logic [1:0] EP_BUF0 = 2'd2;
  localparam logic [1:0] EP_BUF1 = 2'd3;

  state_t r_state, w_state_nxt;

  logic [6:0]  r_fa;
  logic [31:0] r_msk;
  logic        r_src_rst;
  logic        r_src_att;
  logic [31:0] r_ep_csr    [NUM_EP];
  logic [31:0] r_ep_buf0   [NUM_EP];
  logic [31:0] r_ep_buf1   [NUM_EP];
  logic [5:0]  r_ep_en_a   [NUM_EP];
  logic [5:0]  r_ep_en_b   [NUM_EP];
  logic [5:0]  r_ep_sticky [NUM_EP];
  logic [31:0] r_rdata;
  logic        r_inta;
  logic        r_intb;

  logic              w_access;
  logic              w_wr;
  logic              w_rd;
  logic              w_reg_sel;
  logic [7:0]        w_off;
  logic [3:0]        w_ep_idx;
  logic [1:0]        w_ep_reg;
  logic [NUM_EP-1:0] w_ep_sel;
  logic [NUM_EP-1:0] w_ep_src;
  logic [31:0]       w_int_src;
  logic [31:0]       w_rdata;
  logic              w_clr_src;
  logic              w_unused;

  // Address bits that never take part in the decode.
  assign w_unused = ^{wb_addr_i[ADDR_W-2:8], wb_addr_i[1:0]};

  // ---------------- bus FSM ----------------
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_access    = 1'b0;
    case (r_state)
      S_IDLE: if (wb_cyc_i && wb_stb_i) begin
        w_access    = 1'b1;
        w_state_nxt = S_ACK;
      end
      // A strobe still high here is not taken; the next access starts in IDLE.
      S_ACK:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign wb_ack_o = (r_state == S_ACK);
  assign w_wr     = w_access &  wb_we_i;
  assign w_rd     = w_access & ~wb_we_i;

  // ---------------- address decode ----------------
  assign w_reg_sel = wb_addr_i[ADDR_W-1];
  assign w_off     = {wb_addr_i[7:2], 2'b00};
  assign w_ep_idx  = w_off[7:4] - 4'd4;   // endpoint window starts at 0x40
  assign w_ep_reg  = w_off[3:2];

  always_comb begin
    for (int n = 0; n < NUM_EP; n++) begin
      w_ep_sel[n] = w_reg_sel && (w_off[7:6] != 2'b00) && (w_ep_idx == 4'(n));
      w_ep_src[n] = |(r_ep_sticky[n] & r_ep_en_a[n]);
    end
  end

  always_comb begin
    w_int_src              = '0;
    w_int_src[NUM_EP-1:0]  = w_ep_src;
    w_int_src[25]          = r_src_att;
    w_int_src[28]          = r_src_rst;
  end

  assign w_clr_src = w_rd && w_reg_sel && (w_off == OFF_INT_SRC);

  // ---------------- read mux ----------------
  always_comb begin
    w_rdata = '0;
    if (w_reg_sel) begin
      case (w_off)
        OFF_FA:      w_rdata = {25'd0, r_fa};
        OFF_INT_MSK: w_rdata = r_msk;
        OFF_INT_SRC: w_rdata = w_int_src;
        default:     w_rdata = '0;
      endcase
      for (int n = 0; n < NUM_EP; n++) begin
        if (w_ep_sel[n]) begin
          case (w_ep_reg)
            EP_CSR:  w_rdata = r_ep_csr[n];
            EP_INT:  w_rdata = {2'b00, r_ep_en_b[n], 2'b00, r_ep_en_a[n],
                                10'd0, r_ep_sticky[n]};
            EP_BUF0: w_rdata = r_ep_buf0[n];
            EP_BUF1: w_rdata = r_ep_buf1[n];
            default: w_rdata = '0;
          endcase
        end
      end
    end
  end

  // ---------------- register file ----------------
  // NOTE: these register arrays are reset element by element because software
  // relies on every register reading zero after reset; a plain storage RAM
  // would be left unreset.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_fa      <= '0;
      r_msk     <= '0;
      r_src_rst <= 1'b0;
      r_src_att <= 1'b0;
      r_rdata   <= '0;
      r_inta    <= 1'b0;
      r_intb    <= 1'b0;
      for (int n = 0; n < NUM_EP; n++) begin
        r_ep_csr[n]    <= '0;
        r_ep_buf0[n]   <= '0;
        r_ep_buf1[n]   <= '0;
        r_ep_en_a[n]   <= '0;
        r_ep_en_b[n]   <= '0;
        r_ep_sticky[n] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments throughout, so every right-hand side
      // sees the pre-edge register values regardless of statement order.
      r_rdata <= w_rd ? w_rdata : 32'd0;

      if (w_wr && w_reg_sel) begin
        if (w_off == OFF_FA)      r_fa  <= wb_data_i[6:0];
        if (w_off == OFF_INT_MSK) r_msk <= wb_data_i;
      end

      // Sticky bits: an event in the same cycle as the read-clear wins.
      r_src_rst <= (r_src_rst & ~w_clr_src) | usb_rst_i;
      r_src_att <= (r_src_att & ~w_clr_src) | attach_i;

      for (int n = 0; n < NUM_EP; n++) begin
        if (w_wr && w_ep_sel[n]) begin
          case (w_ep_reg)
            EP_CSR:  r_ep_csr[n]  <= wb_data_i;
            EP_INT: begin
              r_ep_en_a[n] <= wb_data_i[21:16];
              r_ep_en_b[n] <= wb_data_i[29:24];
            end
            EP_BUF0: r_ep_buf0[n] <= wb_data_i;
            EP_BUF1: r_ep_buf1[n] <= wb_data_i;
            default: ;
          endcase
        end
        r_ep_sticky[n] <= (r_ep_sticky[n] &
                           ~{6{w_rd && w_ep_sel[n] && (w_ep_reg == EP_INT)}})
                          | ep_evt_i[6*n +: 6];
      end

      r_inta <= |(w_ep_src & r_msk[NUM_EP-1:0])
              | (r_src_rst & r_msk[8])  | (r_src_att & r_msk[9]);
      r_intb <= |(w_ep_src & r_msk[16 +: NUM_EP])
              | (r_src_rst & r_msk[24]) | (r_src_att & r_msk[25]);
    end
  end

  assign wb_data_o = r_rdata;
  assign inta_o    = r_inta;
  assign intb_o    = r_intb;
  assign fa_o      = r_fa;

endmodule
